mmio_periph: RTL and testbench

MMIO_PERIPH -- requirements
Module: mmio_periph

---
 rtl/mmio_periph_pkg.sv | 13 +
 rtl/mmio_periph_pwm8.sv | 12 +
 rtl/mmio_periph.sv | 79 +++++++
 tb/tb_mmio_periph.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mmio_periph_pkg.sv
// mmio_periph_pkg: shared register map and load/store size encodings
package mmio_periph_pkg;
  localparam logic [31:0] WIN_BASE    = 32'hFFFF_FFF0;
  localparam logic [31:0] ADDR_ZERO   = 32'hFFFF_FFF0;
  localparam logic [31:0] ADDR_MICROS = 32'hFFFF_FFF4;
  localparam logic [31:0] ADDR_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] ADDR_PWM    = 32'hFFFF_FFFC;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/mmio_periph_pwm8.sv
// pwm8: registered compare of a shared 8-bit counter against a duty value
module pwm8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty,
  input  logic [7:0] count,
  output logic       out
);
  always_ff @(posedge clk or posedge reset)
    if (reset) out <= 1'b0;
    else out <= count < duty;
endmodule

// File: rtl/mmio_periph.sv
// mmio_periph: memory-mapped PWM register plus free-running micros/millis timers
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);
  localparam int DIV = CLK_FREQ_HZ / 1000000;
  logic [31:0] pwm_reg, micros, millis, presc;
  logic [31:0] rd_word, rd_b_sh, rd_h_sh, rd_val, wmask, wdata;
  logic [9:0]  sub;
  logic [7:0]  pwm_count, rd_b;
  logic [15:0] rd_h;
  logic [3:0]  outs;
  logic        tick, in_win, hit_pwm;
  always_comb begin
    tick    = presc == 32'(DIV - 1);
    in_win  = dmem_address[31:4] == WIN_BASE[31:4];
    hit_pwm = dmem_address[31:2] == ADDR_PWM[31:2];
    rd_word = !in_win ? 32'd0 :
              dmem_address[3:2] == ADDR_PWM[3:2]    ? pwm_reg :
              dmem_address[3:2] == ADDR_MILLIS[3:2] ? millis :
              dmem_address[3:2] == ADDR_MICROS[3:2] ? micros : 32'd0;
    rd_b_sh = rd_word >> {dmem_address[1:0], 3'b000};
    rd_h_sh = rd_word >> {dmem_address[1], 4'b0000};
    rd_b    = rd_b_sh[7:0];
    rd_h    = rd_h_sh[15:0];
    rd_val  = funct3 == F3_B  ? {{24{rd_b[7]}}, rd_b} :
              funct3 == F3_BU ? {24'd0, rd_b} :
              funct3 == F3_H  ? {{16{rd_h[15]}}, rd_h} :
              funct3 == F3_HU ? {16'd0, rd_h} : rd_word;
    // Stores are right-aligned; replicate so the lane mask picks the right copy
    wmask   = funct3 == F3_B ? 32'h0000_00FF << {dmem_address[1:0], 3'b000} :
              funct3 == F3_H ? 32'h0000_FFFF << {dmem_address[1], 4'b0000} : 32'hFFFF_FFFF;
    wdata   = funct3 == F3_B ? {4{dmem_data_in[7:0]}} :
              funct3 == F3_H ? {2{dmem_data_in[15:0]}} : dmem_data_in;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dmem_data_out <= '0;
      pwm_reg       <= '0;
      micros        <= '0;
      millis        <= '0;
      presc         <= '0;
      sub           <= '0;
      pwm_count     <= '0;
    end else begin
      dmem_data_out <= rd_val;
      if (dmem_wren && hit_pwm) pwm_reg <= (pwm_reg & ~wmask) | (wdata & wmask);
      pwm_count <= pwm_count + 8'd1;
      presc     <= tick ? '0 : presc + 32'd1;
      if (tick) begin
        micros <= micros + 32'd1;
        sub    <= sub == 10'd999 ? 10'd0 : sub + 10'd1;
        if (sub == 10'd999) millis <= millis + 32'd1;
      end
    end
  for (genvar i = 0; i < 4; i++) begin : g_pwm
    pwm8 u_pwm (
      .clk  (clk),
      .reset(reset),
      .duty (pwm_reg[8*i +: 8]),
      .count(pwm_count),
      .out  (outs[i])
    );
  end
  assign {led, red, green, blue} = outs;
endmodule

// File: tb/tb_mmio_periph.sv
// tb_mmio_periph: directed checks of register access, timers and PWM duty
module tb_mmio_periph;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  funct3 = 3'b010;
  logic        dmem_wren = 1'b0;
  logic [31:0] dmem_address = 32'd0;
  logic [31:0] dmem_data_in = 32'd0;
  logic [31:0] dmem_data_out;
  logic        led, red, green, blue;
  int checks = 0;
  int failures = 0;
  int nl, nr, ng, nb;

  mmio_periph #(.CLK_FREQ_HZ(12000000)) dut (
    .clk(clk), .reset(reset), .funct3(funct3), .dmem_wren(dmem_wren),
    .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
    .dmem_data_out(dmem_data_out), .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one access at a negedge; it is sampled at the following posedge.
  task automatic access(input logic we, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    dmem_wren = we;
    dmem_address = a;
    funct3 = f;
    dmem_data_in = d;
    @(negedge clk);
    dmem_wren = 1'b0;
  endtask

  task automatic count_high();
    nl = 0; nr = 0; ng = 0; nb = 0;
    repeat (256) begin
      @(negedge clk);
      nl += int'(led); nr += int'(red); ng += int'(green); nb += int'(blue);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", dmem_data_out, 32'h0);
    check("rst_outs", {28'd0, led, red, green, blue}, 32'h0);
    reset = 1'b0;
    access(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0);
    check("lw_pwm_after_rst", dmem_data_out, 32'h0);
    count_high();
    check("outs_low_after_rst", 32'(nl + nr + ng + nb), 32'd0);

    access(1'b1, 32'hFFFF_FFFC, 3'b010, 32'hFFFF_0000);
    access(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0);
    check("lw_ffff0000", dmem_data_out, 32'hFFFF_0000);
    count_high();
    check("led_255", 32'(nl), 32'd255);
    check("red_255", 32'(nr), 32'd255);
    check("green_0", 32'(ng), 32'd0);
    check("blue_0", 32'(nb), 32'd0);

    access(1'b1, 32'hFFFF_FFFD, 3'b000, 32'h0000_0080);
    access(1'b0, 32'hFFFF_FFFD, 3'b000, 32'h0);
    check("lb_fd", dmem_data_out, 32'hFFFF_FF80);
    access(1'b0, 32'hFFFF_FFFD, 3'b100, 32'h0);
    check("lbu_fd", dmem_data_out, 32'h0000_0080);
    access(1'b0, 32'hFFFF_FFFC, 3'b001, 32'h0);
    check("lh_fc", dmem_data_out, 32'hFFFF_8000);
    access(1'b0, 32'hFFFF_FFFE, 3'b101, 32'h0);
    check("lhu_fe", dmem_data_out, 32'h0000_FFFF);
    access(1'b0, 32'hFFFF_FFFF, 3'b000, 32'h0);
    check("lb_ff", dmem_data_out, 32'hFFFF_FFFF);
    access(1'b0, 32'hFFFF_FFFC, 3'b111, 32'h0);
    check("undef_f3_as_lw", dmem_data_out, 32'hFFFF_8000);
    count_high();
    check("green_128", 32'(ng), 32'd128);
    check("blue_0_b", 32'(nb), 32'd0);

    access(1'b1, 32'hFFFF_FFFE, 3'b001, 32'h0000_1234);
    access(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0);
    check("sh_upper", dmem_data_out, 32'h1234_8000);
    access(1'b1, 32'hFFFF_FFFD, 3'b001, 32'h0000_ABCD);
    access(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0);
    check("sh_lower_a0_ignored", dmem_data_out, 32'h1234_ABCD);
    access(1'b1, 32'hFFFF_FFFC, 3'b010, 32'h1122_3344);
    check("rw_same_cycle_old", dmem_data_out, 32'h1234_ABCD);
    access(1'b0, 32'hFFFF_FFFD, 3'b010, 32'h0);
    check("lw_word_ignores_lane", dmem_data_out, 32'h1122_3344);

    access(1'b1, 32'h0000_1000, 3'b010, 32'hDEAD_BEEF);
    access(1'b1, 32'hFFFF_FFF0, 3'b010, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_1000, 3'b010, 32'h0);
    check("outside_reads_zero", dmem_data_out, 32'h0);
    access(1'b0, 32'hFFFF_FFF0, 3'b010, 32'h0);
    check("zero_reg_reads_zero", dmem_data_out, 32'h0);
    access(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0);
    check("pwm_untouched", dmem_data_out, 32'h1122_3344);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (11) @(negedge clk);
    access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0);
    check("micros_before_first_tick", dmem_data_out, 32'd0);
    access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0);
    check("micros_first_tick", dmem_data_out, 32'd1);
    repeat (11987) @(negedge clk);
    access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0);
    check("micros_1000", dmem_data_out, 32'd1000);
    access(1'b0, 32'hFFFF_FFF8, 3'b010, 32'h0);
    check("millis_1", dmem_data_out, 32'd1);
    access(1'b1, 32'hFFFF_FFF8, 3'b010, 32'h1234_5678);
    access(1'b0, 32'hFFFF_FFF8, 3'b010, 32'h0);
    check("millis_ro", dmem_data_out, 32'd1);

    for (int i = 0; i < 20 && dut.presc != 32'd1; i++) @(negedge clk);
    check("presc_sync", dut.presc, 32'd1);
    force dut.micros = 32'hFFFF_FFFF;
    release dut.micros;
    repeat (9) @(negedge clk);
    access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0);
    check("micros_forced", dmem_data_out, 32'hFFFF_FFFF);
    access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0);
    access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0);
    check("micros_wrap", dmem_data_out, 32'h0);
    access(1'b0, 32'hFFFF_FFF8, 3'b010, 32'h0);
    check("millis_after_wrap", dmem_data_out, 32'd1);
    access(1'b0, 32'h0000_1000, 3'b010, 32'h0);
    check("lw_1000", dmem_data_out, 32'h0);

    access(1'b1, 32'hFFFF_FFFC, 3'b010, 32'hFFFF_FFFF);
    access(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0);
    check("pwm_all_ff", dmem_data_out, 32'hFFFF_FFFF);
    count_high();
    check("all_outs_255", 32'(nl + nr + ng + nb), 32'd1020);
    dmem_wren = 1'b1;
    dmem_address = 32'hFFFF_FFFC;
    funct3 = 3'b010;
    dmem_data_in = 32'h5555_5555;
    reset = 1'b1;
    #1;
    check("async_rst_data", dmem_data_out, 32'h0);
    check("async_rst_outs", {28'd0, led, red, green, blue}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dmem_wren = 1'b0;
    access(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0);
    check("write_lost_in_rst", dmem_data_out, 32'h0);
    count_high();
    check("outs_low_after_rst2", 32'(nl + nr + ng + nb), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
